random_checker: RTL and testbench
=================================

# random_checker

Receive-side checker for the 8-bit pseudo-random stream produced by the game's LFSR generator. It synchronises to the incoming sequence, then predicts each next value locally and flags, counts and reports mismatches. It sits beside the random source and verifies the stream on the board and in simulation without disturbing the game logic.

## Interface
- LOCK_CNT, 4, number of consecutive correct predictions in HUNT required to lock (1..15)
- UNLOCK_CNT, 3, number of consecutive mispredictions in LOCKED that drop lock (1..15)
- CNT_W, 16, width of the saturating error counter (≥2)
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rand_valid  in  1  rand_in is a new sample this cycle
- rand_in  in  8  sample from the generator
- clear_cnt  in  1  synchronous clear of err_count and sticky flags
- locked  out  1  checker is synchronised to the stream
- err_pulse  out  1  one-cycle pulse per mismatching sample while locked
- err_count  out  CNT_W  saturating mismatch count
- stuck_zero  out  1  sticky all-zero-sample flag; tied 0 when the feature is compiled out

## Operation
- Next-state function: next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. The tap mask is 8'hB8.
- Internal state: pred[7:0], seeded, hunt_cnt, miss_cnt, and FSM {HUNT, LOCKED}.
- Reset values: FSM=HUNT, pred=0, seeded=0, hunt_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, stuck_zero=0.
- When rand_valid=0, no state changes and err_pulse=0.
- HUNT, on each valid sample:
  - If seeded and rand_in==pred, hunt_cnt increments. Otherwise hunt_cnt is set to 0.
  - seeded is set to 1 and pred is set to next(rand_in).
  - When the increment makes hunt_cnt==LOCK_CNT, the FSM moves to LOCKED and miss_cnt is set to 0.
  - Locking therefore needs LOCK_CNT+1 samples.
  - No errors are counted in HUNT.
- LOCKED, on each valid sample (flywheel: the checker predicts from its own state):
  - pred is set to next(pred). A single corrupted sample therefore produces exactly one error.
  - Mismatch: err_pulse=1, err_count increments and saturates at all-ones, miss_cnt increments.
  - Match: miss_cnt is set to 0.
  - When miss_cnt reaches UNLOCK_CNT, the FSM moves to HUNT with seeded=0 and hunt_cnt=0. The sample that caused the unlock still counts as an error.
- clear_cnt:
  - Sets err_count=0 and stuck_zero=0 on the next edge.
  - If clear_cnt coincides with a mismatch, the clear wins: err_count becomes 0 and err_pulse still fires.
  - clear_cnt does not affect the FSM or the lock state.
- rst during LOCKED returns every register to its reset value on that edge.

## Timing
- All outputs are registered.
- err_pulse, err_count and locked update on the edge that samples the relevant rand_valid. They are visible the following cycle.
- Maximum rate: one sample per clock. There is no backpressure and no ready signal.
- Latency from sample to flag is 1 cycle.

## Configuration
- RANDOM_CHECKER_STUCK_DETECT_EN is the only compile-time option.
- When defined:
  - A valid rand_in==8'h00 sets stuck_zero. The flag stays set until rst or clear_cnt.
  - In HUNT, a zero sample forces seeded=0 and hunt_cnt=0, because the all-zero state is the generator's lockup state and must never seed.
  - In LOCKED, a zero sample is an ordinary mismatch.
- When undefined, stuck_zero is tied 0 and zero samples are treated as ordinary data.

## Structure
- Shared package random_pkg holds:
  - LFSR_W=8
  - LFSR_TAPS=8'hB8
  - function lfsr_next(x), which the generator also uses
  - the FSM enum typedef {HUNT, LOCKED}
- Single module; no sub-module is warranted.

## Test plan
- Lock: after rst, feed FF,FE,FC,F8,F0 on consecutive cycles -> locked=1 in the cycle after F0 is sampled; err_count=0.
- Single error: after locking, feed E0 (expected E1), then C2 -> exactly one err_pulse; err_count=1; locked stays 1.
- Unlock then relock: while locked, feed three wrong samples -> err_count increases by 3 and locked=0 after the third. Then feed a valid 5-sample run -> locked=1 again.
- Saturation and clear (CNT_W=4): sustain mismatches by alternating lock runs and errors past 15 -> err_count holds 4'hF. Assert clear_cnt together with a mismatch -> err_count=0 and err_pulse=1.
- Gaps and reset: insert idle rand_valid=0 cycles between samples -> behaviour is identical to back-to-back samples. Assert rst while locked -> all outputs are 0 on the next cycle.
- Stuck (macro on): feed 00 in HUNT -> stuck_zero=1 and no lock after FF,FE,FC,F8 (only 4 samples). Assert clear_cnt -> stuck_zero=0. With the macro off -> stuck_zero stays 0.

Source files
------------

// File: rtl/random_pkg.sv
// Shared definitions for the 8-bit game LFSR: width, tap mask, step function
// and the checker FSM state type.
package random_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Left shift with XOR of taps 7,5,4,3 fed into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ^(x & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/random_checker_if.sv
// Sample/status bundle between the random source side and random_checker.
interface random_checker_if
  import random_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic              rand_valid;
  logic [LFSR_W-1:0] rand_in;
  logic              clear_cnt;
  logic              locked;
  logic              err_pulse;
  logic [CNT_W-1:0]  err_count;
  logic              stuck_zero;

  modport master (
    output rand_valid, rand_in, clear_cnt,
    input  locked, err_pulse, err_count, stuck_zero
  );

  modport slave (
    input  rand_valid, rand_in, clear_cnt,
    output locked, err_pulse, err_count, stuck_zero
  );

endinterface

// File: rtl/random_checker.sv
// Receive-side checker for the game LFSR stream: hunts for sync, then flywheels
// its own prediction and counts mismatches. Option: RANDOM_CHECKER_STUCK_DETECT_EN.
module random_checker
  import random_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  random_checker_if.slave  bus
);

  localparam int unsigned RUN_W = 4;

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic              seeded_q, seeded_d;
  logic [RUN_W-1:0]  hunt_cnt_q, hunt_cnt_d;
  logic [RUN_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic [RUN_W-1:0]  hunt_inc;
  logic [RUN_W-1:0]  miss_inc;
  logic              match;
  logic              zero_smp;

  assign hunt_inc = hunt_cnt_q + RUN_W'(1);
  assign miss_inc = miss_cnt_q + RUN_W'(1);
  assign match    = (bus.rand_in == pred_q);

`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
  logic stuck_zero_q, stuck_zero_d;

  // The all-zero word is the generator's lockup state and must never seed.
  assign zero_smp = bus.rand_valid && (bus.rand_in == '0);
`else
  assign zero_smp = 1'b0;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      pred_q      <= '0;
      seeded_q    <= 1'b0;
      hunt_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      seeded_q    <= seeded_d;
      hunt_cnt_q  <= hunt_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_zero_q <= 1'b0;
    end else begin
      stuck_zero_q <= stuck_zero_d;
    end
  end
`endif

  // Next-state: hunt/lock FSM, prediction, run counters, error accounting.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    seeded_d    = seeded_q;
    hunt_cnt_d  = hunt_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
    stuck_zero_d = stuck_zero_q;
`endif

    if (bus.rand_valid) begin
      case (state_q)
        HUNT: begin
          seeded_d = 1'b1;
          pred_d   = lfsr_next(bus.rand_in);
          if (seeded_q && match && !zero_smp) begin
            hunt_cnt_d = hunt_inc;
            if (hunt_inc == RUN_W'(LOCK_CNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            hunt_cnt_d = '0;
          end
          if (zero_smp) begin
            seeded_d = 1'b0;
          end
        end

        LOCKED: begin
          // Flywheel: one corrupted sample costs exactly one error.
          pred_d = lfsr_next(pred_q);
          if (!match) begin
            err_pulse_d = 1'b1;
            miss_cnt_d  = miss_inc;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_inc == RUN_W'(UNLOCK_CNT)) begin
              state_d    = HUNT;
              seeded_d   = 1'b0;
              hunt_cnt_d = '0;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
    if (zero_smp) begin
      stuck_zero_d = 1'b1;
    end
`endif

    // Clear beats a coincident increment; err_pulse is unaffected.
    if (bus.clear_cnt) begin
      err_count_d = '0;
`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
      stuck_zero_d = 1'b0;
`endif
    end

    locked_d = (state_d == LOCKED);
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
  assign bus.stuck_zero = stuck_zero_q;
`else
  assign bus.stuck_zero = 1'b0;
`endif

endmodule

// File: tb/tb_random_checker.sv
// Directed self-checking bench for random_checker (CNT_W=4 so saturation is reachable).
module tb_random_checker;
  import random_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  random_checker_if #(.CNT_W(CNT_W)) bus ();

  random_checker #(
    .LOCK_CNT  (4),
    .UNLOCK_CNT(3),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of input; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic clr);
    bus.rand_valid = v;
    bus.rand_in    = d;
    bus.clear_cnt  = clr;
    @(posedge clk);
    #1;
    bus.rand_valid = 1'b0;
    bus.rand_in    = 8'h00;
    bus.clear_cnt  = 1'b0;
  endtask

  task automatic smp(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  // FF,FE,FC,F8,F0 is a legal run; lock lands on the F0 edge.
  task automatic lock_run(input string tag, input int gap);
    logic [7:0] seq [5];
    seq = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
    for (int i = 0; i < 5; i++) begin
      smp(seq[i]);
      if (i == 3) check({tag, "_prelock"}, 32'(bus.locked), 32'd0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, 1'b0);
    end
    check({tag, "_lock"}, 32'(bus.locked), 32'd1);
  endtask

  // Three wrong samples against predictions E1,C2,85 unlock the checker.
  task automatic unlock_run(input string tag);
    smp(8'h11);
    smp(8'h22);
    check({tag, "_still_locked"}, 32'(bus.locked), 32'd1);
    smp(8'h33);
    check({tag, "_unlocked"}, 32'(bus.locked), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.rand_valid = 1'b0;
    bus.rand_in    = 8'h00;
    bus.clear_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(bus.locked),     32'd0);
    check("rst_pulse",  32'(bus.err_pulse),  32'd0);
    check("rst_count",  32'(bus.err_count),  32'd0);
    check("rst_stuck",  32'(bus.stuck_zero), 32'd0);
    rst = 1'b0;

    lock_run("l1", 0);
    check("l1_count", 32'(bus.err_count), 32'd0);

    // Single corrupted sample: E0 instead of E1, then C2 resumes cleanly.
    smp(8'hE0);
    check("single_pulse",  32'(bus.err_pulse), 32'd1);
    check("single_count",  32'(bus.err_count), 32'd1);
    check("single_locked", 32'(bus.locked),    32'd1);
    smp(8'hC2);
    check("single_pulse_off", 32'(bus.err_pulse), 32'd0);
    check("single_count_hold", 32'(bus.err_count), 32'd1);

    // After E0/C2 the next predictions are 85,0B,17.
    smp(8'h11);
    smp(8'h22);
    smp(8'h33);
    check("unl_locked", 32'(bus.locked),    32'd0);
    check("unl_count",  32'(bus.err_count), 32'd4);
    lock_run("relock", 0);
    exp_cnt = 4;

    // Repeated unlock/relock drives the 4-bit counter into saturation.
    for (int i = 0; i < 4; i++) begin
      unlock_run("sat");
      exp_cnt = (exp_cnt + 3 > 15) ? 15 : exp_cnt + 3;
      check("sat_count", 32'(bus.err_count), 32'(exp_cnt));
      lock_run("sat_relock", 0);
    end
    check("sat_hold", 32'(bus.err_count), 32'hF);

    // Clear coinciding with a mismatch: count clears, pulse still fires.
    cyc(1'b1, 8'h11, 1'b1);
    check("clr_pulse",  32'(bus.err_pulse), 32'd1);
    check("clr_count",  32'(bus.err_count), 32'd0);
    check("clr_locked", 32'(bus.locked),    32'd1);
    smp(8'hC2);
    check("clr_match_pulse", 32'(bus.err_pulse), 32'd0);
    check("clr_match_count", 32'(bus.err_count), 32'd0);

    // Idle cycles between samples must not disturb hunting or errors.
    rst_pulse();
    lock_run("gap", 2);
    cyc(1'b0, 8'h00, 1'b0);
    smp(8'hE0);
    check("gap_pulse", 32'(bus.err_pulse), 32'd1);
    check("gap_count", 32'(bus.err_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    check("gap_pulse_off", 32'(bus.err_pulse), 32'd0);
    check("gap_count_hold", 32'(bus.err_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    smp(8'hC2);
    check("gap_resync", 32'(bus.err_pulse), 32'd0);

    // Reset while locked clears everything on the same edge.
    rst_pulse();
    check("lrst_locked", 32'(bus.locked),     32'd0);
    check("lrst_pulse",  32'(bus.err_pulse),  32'd0);
    check("lrst_count",  32'(bus.err_count),  32'd0);
    check("lrst_stuck",  32'(bus.stuck_zero), 32'd0);

    // Five zero samples: ordinary data locks (next(00)=00), stuck detect never seeds.
    for (int i = 0; i < 5; i++) smp(8'h00);
`ifdef RANDOM_CHECKER_STUCK_DETECT_EN
    check("zero_locked", 32'(bus.locked),     32'd0);
    check("zero_stuck",  32'(bus.stuck_zero), 32'd1);
    smp(8'hFF);
    smp(8'hFE);
    smp(8'hFC);
    smp(8'hF8);
    check("zero_4smp", 32'(bus.locked), 32'd0);
    smp(8'hF0);
    check("zero_then_lock", 32'(bus.locked), 32'd1);
    check("zero_stuck_hold", 32'(bus.stuck_zero), 32'd1);
`else
    check("zero_locked", 32'(bus.locked),     32'd1);
    check("zero_stuck",  32'(bus.stuck_zero), 32'd0);
`endif
    cyc(1'b0, 8'h00, 1'b1);
    check("stuck_clr", 32'(bus.stuck_zero), 32'd0);
    check("stuck_clr_locked", 32'(bus.locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
